// File: rtl/seg7_pkg.sv
// seg7_pkg: hex font table and segment bit positions shared by the seg7 scan blocks
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G + 1;

    // entry n is the active-high segment pattern for hex digit n
    localparam logic [15:0][SEG_W-1:0] FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [SEG_W-1:0] font_lookup(input logic [3:0] nibble);
        return FONT[nibble];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-high 7-segment pattern
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    assign seg = font_lookup(nibble);

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-segment scanner with tear-free frame updates.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic                    frame
);

    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic INV = ACTIVE_LOW != 0;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] val;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   bl;
    } disp_t;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  tc;
    logic                  wrap;
    disp_t                 pend;
    disp_t                 act;
    logic [3:0]            nib;
    logic [SEG_W-1:0]      font_seg;
    logic [NUM_DIGITS-1:0] lz;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic                  zero_run;
`endif

    assign tc   = cnt == CNT_MAX;
    assign wrap = tc && (idx == IDX_MAX);
    assign nib  = act.val[4*idx +: 4];

    seg7_decode u_decode (
        .nibble (nib),
        .seg    (font_seg)
    );

    // refresh counter, digit index and one-cycle frame pulse after each wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            frame <= 1'b0;
        end else begin
            cnt   <= tc ? '0 : cnt + 1'b1;
            idx   <= wrap ? '0 : (tc ? idx + 1'b1 : idx);
            frame <= wrap;
        end
    end

    // loads land in pending; active only changes on the wrap so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            act  <= '0;
        end else begin
            if (load)
                pend <= {value, dp_in, blank};
            if (wrap)
                act <= pend;
        end
    end

    // leading-zero mask: zero nibbles from the top down, digit 0 always shown
    always_comb begin
        lz = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (act.val[4*i +: 4] == 4'h0);
            lz[i]    = zero_run;
        end
`endif
    end

    // registered outputs follow the index one cycle later; blanking keeps the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg   <= {SEG_W{INV}};
            dp    <= INV;
            digit <= {NUM_DIGITS{INV}};
        end else begin
            seg   <= ((act.bl[idx] || lz[idx]) ? '0 : font_seg) ^ {SEG_W{INV}};
            dp    <= (act.dp[idx] && !act.bl[idx]) ^ INV;
            digit <= (NUM_DIGITS'(1) << idx) ^ {NUM_DIGITS{INV}};
        end
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000, SHALL set the clock cycles each digit is held; legal minimum 1.
REQ-003 Parameter ACTIVE_LOW, default 0, SHALL invert seg, dp and digit when set to 1, for common-anode boards.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 value  input  4*NUM_DIGITS  SHALL carry hex nibbles; nibble i drives digit i, and digit 0 is least significant.
REQ-007 dp_in  input  NUM_DIGITS  SHALL carry the per-digit decimal-point request.
REQ-008 blank  input  NUM_DIGITS  SHALL carry the per-digit blank request.
REQ-009 load  input  1  SHALL be a one-cycle strobe that captures value, dp_in and blank.
REQ-010 seg  output  7  SHALL drive the segments, bit0=a through bit6=g.
REQ-011 dp  output  1  SHALL drive the decimal-point segment.
REQ-012 digit  output  NUM_DIGITS  SHALL drive the one-hot digit enable.
REQ-013 frame  output  1  SHALL pulse high for one cycle on each scan wrap.

Function
REQ-014 The block SHALL keep a refresh counter that counts 0..REFRESH_DIV-1; at the terminal count it returns to 0 and the digit index increments.
REQ-015 The digit index SHALL wrap from NUM_DIGITS-1 to 0; frame SHALL assert in the cycle after the wrap.
REQ-016 With NUM_DIGITS=1 the index SHALL stay 0, and frame SHALL pulse every REFRESH_DIV cycles.
REQ-017 A load strobe SHALL capture the inputs into a pending register; if several loads occur in one frame, the last one wins.
REQ-018 The pending register SHALL copy into the active register on the index wrap, giving tear-free updates. A load in the wrap cycle SHALL take effect at the following wrap.
REQ-019 seg, dp and digit SHALL be registered and SHALL reflect the new index one cycle after it changes.
REQ-020 Decode (active-high) SHALL be the hex font 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-021 For a blanked digit, seg and dp SHALL be inactive while the digit enable still strobes, so scan timing is unchanged.
REQ-022 Exactly one digit bit SHALL be active at any time outside reset.

Reset
REQ-023 While rst_n=0 the following SHALL hold immediately:
- counter, index, pending and active registers = 0;
- seg, dp and digit at their inactive level (all 0 when ACTIVE_LOW=0, all 1 otherwise);
- frame = 0.
REQ-024 After rst_n releases, scanning SHALL start at digit 0 with the counter at 0, and the first digit enable SHALL appear one cycle later.
REQ-025 A reset mid-frame SHALL discard pending data.

Configuration
REQ-026 With SEG7_LEADING_ZERO_BLANK_EN defined, the block SHALL blank zero nibbles counting from the most significant digit down to the first nonzero nibble. Digit 0 is never blanked by this rule, and dp_in still shows on blanked digits.
REQ-027 Without SEG7_LEADING_ZERO_BLANK_EN, every zero nibble SHALL display as 3F.

Structure
REQ-028 Package seg7_pkg SHALL hold the 16-entry font constant table and segment-bit index constants.
REQ-029 The sub-module seg7_decode SHALL be combinational: nibble in, 7-bit active-high segments out. seg7_scan SHALL instantiate it once on the muxed nibble.

Verification
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0.
REQ-030 Reset then load value=16'h1234 -> after the first wrap, slot digit=0001 shows seg=66 and slot digit=1000 shows seg=06.
REQ-031 Free run -> digit sequence 0001,0010,0100,1000, each held 4 cycles; frame pulses once per 16 cycles.
REQ-032 Load 16'hABCD while 16'h1234 is displayed, at digit 1 -> 1234 continues until the wrap; the next frame shows digit0 seg=5E.
REQ-033 blank=4'b1000 with dp_in=4'b1000 -> digit3 slot gives digit=1000, seg=00, dp=0.
REQ-034 value=16'h0070 -> with the macro: digit3 and digit2 seg=00, digit1 seg=07, digit0 seg=3F. Without the macro: digit3 seg=3F.
REQ-035 rst_n low at cycle 7 -> digit=0000 and seg=00 in the same cycle without a clock edge; after release, digit=0001 on the second edge.
